// File: rtl/ats21_pkg.sv
// ats21_pkg
//   Shared types and constants for the ATS21 two-client command arbiter:
//   FSM state encoding, client identifiers, ATS21 bus widths and the status
//   code reported when ATS21 never answers.
package ats21_pkg;

    localparam int ATS_CTRL_W = 16;
    localparam int ATS_DATA_W = 24;
    localparam int ATS_STAT_W = 2;
    localparam int CMD_W      = 2 * ATS_CTRL_W;

    localparam logic [ATS_STAT_W-1:0] STAT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        CLI_A,
        CLI_B
    } cli_e;

endpackage

// File: rtl/ats21_rr_arb.sv
// ats21_rr_arb
//   Combinational two-way round-robin decision.
//   Ports:
//     req_a, req_b  - client has a pending command
//     last_grant    - client served most recently
//     grant_valid   - at least one request present
//     grant         - client to serve (A when only A, B when only B,
//                     the one not served last when both)
module ats21_rr_arb
    import ats21_pkg::*;
(
    input  logic req_a,
    input  logic req_b,
    input  cli_e last_grant,
    output logic grant_valid,
    output cli_e grant
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        grant_valid = req_a | req_b;
        grant       = CLI_A;
        if (req_a && req_b) begin
            grant = (last_grant == CLI_A) ? CLI_B : CLI_A;
        end else if (req_b) begin
            grant = CLI_B;
        end
    end

endmodule

// File: rtl/ats21_arbiter.sv
// ats21_arbiter
//   Shares one ATS21 command port between two clients (A and B). Each client
//   has a one-entry holding register; the FSM issues one command at a time,
//   waits for ATS21 (bounded by TIMEOUT_CYCLES) and returns the response to
//   the client that issued it.
//   Ports:
//     clk, reset_n                  - clock, async active-low reset
//     x_valid/x_ready/x_cmd         - client command handshake (x = a, b);
//                                     cmd[31:16] -> ats_ctrlA, [15:0] -> ats_ctrlB
//     x_rsp_valid/x_rsp_stat/x_rsp_data - one-cycle response strobe + payload
//     ats_req/ats_ctrlA/ats_ctrlB   - one-cycle request and command to ATS21
//     ats_ready/ats_stat/ats_data   - ATS21 response
//     busy                          - FSM not idle
//     timeout_err                   - one-cycle pulse on a timed-out command
module ats21_arbiter
    import ats21_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic [CMD_W-1:0]      a_cmd,
    output logic                  a_rsp_valid,
    output logic [ATS_STAT_W-1:0] a_rsp_stat,
    output logic [ATS_DATA_W-1:0] a_rsp_data,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [CMD_W-1:0]      b_cmd,
    output logic                  b_rsp_valid,
    output logic [ATS_STAT_W-1:0] b_rsp_stat,
    output logic [ATS_DATA_W-1:0] b_rsp_data,

    output logic                  ats_req,
    output logic [ATS_CTRL_W-1:0] ats_ctrlA,
    output logic [ATS_CTRL_W-1:0] ats_ctrlB,
    input  logic                  ats_ready,
    input  logic [ATS_STAT_W-1:0] ats_stat,
    input  logic [ATS_DATA_W-1:0] ats_data,

    output logic                  busy,
    output logic                  timeout_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state;
    cli_e                    gnt;
    cli_e                    last_grant;
    logic                    pend_a;
    logic                    pend_b;
    logic [CMD_W-1:0]        hold_a;
    logic [CMD_W-1:0]        hold_b;
    logic [CNT_W-1:0]        wait_cnt;

    logic                    arb_valid;
    cli_e                    arb_grant;
    logic                    acc_a;
    logic                    acc_b;
    logic                    done_a;
    logic                    done_b;
    logic                    wait_done;
    logic [ATS_STAT_W-1:0]   nxt_stat;
    logic [ATS_DATA_W-1:0]   nxt_data;

    assign a_ready = !pend_a;
    assign b_ready = !pend_b;
    assign busy    = (state != ST_IDLE);

    assign acc_a  = a_valid && !pend_a;
    assign acc_b  = b_valid && !pend_b;
    assign done_a = (state == ST_RESP) && (gnt == CLI_A);
    assign done_b = (state == ST_RESP) && (gnt == CLI_B);

    // A real response wins over a timeout landing in the same cycle.
    assign wait_done = ats_ready || (wait_cnt == CNT_LAST);
    assign nxt_stat  = ats_ready ? ats_stat : STAT_TIMEOUT;
    assign nxt_data  = ats_ready ? ats_data : '0;

    ats21_rr_arb u_rr_arb (
        .req_a       (pend_a),
        .req_b       (pend_b),
        .last_grant  (last_grant),
        .grant_valid (arb_valid),
        .grant       (arb_grant)
    );

    // Holding registers. A pending entry is only released in RESP, when the
    // client's ready is low, so capture and release never coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            if (acc_a) begin
                pend_a <= 1'b1;
                hold_a <= a_cmd;
            end else if (done_a) begin
                pend_a <= 1'b0;
            end
            if (acc_b) begin
                pend_b <= 1'b1;
                hold_b <= b_cmd;
            end else if (done_b) begin
                pend_b <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            gnt         <= CLI_A;
            last_grant  <= CLI_B;
            wait_cnt    <= '0;
            ats_req     <= 1'b0;
            ats_ctrlA   <= '0;
            ats_ctrlB   <= '0;
            a_rsp_valid <= 1'b0;
            a_rsp_stat  <= '0;
            a_rsp_data  <= '0;
            b_rsp_valid <= 1'b0;
            b_rsp_stat  <= '0;
            b_rsp_data  <= '0;
            timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking defaults make the pulse outputs one cycle
            // wide; a later assignment in the same edge overrides them.
            ats_req     <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
            timeout_err <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        gnt <= arb_grant;
                        {ats_ctrlA, ats_ctrlB} <= (arb_grant == CLI_A) ? hold_a : hold_b;
                        ats_req <= 1'b1;
                        state   <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    wait_cnt <= '0;
                    state    <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (wait_done) begin
                        if (gnt == CLI_A) begin
                            a_rsp_valid <= 1'b1;
                            a_rsp_stat  <= nxt_stat;
                            a_rsp_data  <= nxt_data;
                        end else begin
                            b_rsp_valid <= 1'b1;
                            b_rsp_stat  <= nxt_stat;
                            b_rsp_data  <= nxt_data;
                        end
                        timeout_err <= !ats_ready;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_RESP: begin
                    last_grant <= gnt;
                    state      <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ats21_arbiter.sv
// tb_ats21_arbiter
//   Directed bench for ats21_arbiter (TIMEOUT_CYCLES = 8). Inputs are driven
//   and outputs sampled on the falling clock edge; expected values are hand
//   computed from the arbiter's cycle behaviour.
module tb_ats21_arbiter;
    import ats21_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  a_valid, b_valid;
    logic                  a_ready, b_ready;
    logic [31:0]           a_cmd, b_cmd;
    logic                  a_rsp_valid, b_rsp_valid;
    logic [1:0]            a_rsp_stat, b_rsp_stat;
    logic [23:0]           a_rsp_data, b_rsp_data;
    logic                  ats_req;
    logic [15:0]           ats_ctrlA, ats_ctrlB;
    logic                  ats_ready;
    logic [1:0]            ats_stat;
    logic [23:0]           ats_data;
    logic                  busy, timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    int req_cnt = 0;
    int a_rsp_cnt = 0;
    int b_rsp_cnt = 0;

    always #5 clk = ~clk;

    ats21_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_cmd       (a_cmd),
        .a_rsp_valid (a_rsp_valid),
        .a_rsp_stat  (a_rsp_stat),
        .a_rsp_data  (a_rsp_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_cmd       (b_cmd),
        .b_rsp_valid (b_rsp_valid),
        .b_rsp_stat  (b_rsp_stat),
        .b_rsp_data  (b_rsp_data),
        .ats_req     (ats_req),
        .ats_ctrlA   (ats_ctrlA),
        .ats_ctrlB   (ats_ctrlB),
        .ats_ready   (ats_ready),
        .ats_stat    (ats_stat),
        .ats_data    (ats_data),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // Pulse counters, sampled just after each rising edge.
    always @(posedge clk) begin
        #1;
        if (ats_req)     req_cnt++;
        if (a_rsp_valid) a_rsp_cnt++;
        if (b_rsp_valid) b_rsp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Wait (bounded) until ats_req is high at a falling edge.
    task automatic wait_req(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (ats_req) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check("ats_req_seen", 32'(seen), 32'd1);
    endtask

    // Called in the ISSUE cycle; ats_ready is presented dly cycles later.
    // Returns at the falling edge of the RESP cycle.
    task automatic respond(input int dly, input logic [1:0] st, input logic [23:0] dt);
        repeat (dly) tick();
        ats_ready = 1'b1;
        ats_stat  = st;
        ats_data  = dt;
        tick();
        ats_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic drive_a(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            a_cmd   = {16'hA000 + 16'(i), 16'h0000};
            a_valid = 1'b1;
            while (!a_ready && guard < 200) begin
                tick();
                guard++;
            end
            tick();
        end
        a_valid = 1'b0;
    endtask

    task automatic drive_b(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            b_cmd   = {16'hB000 + 16'(i), 16'h0000};
            b_valid = 1'b1;
            while (!b_ready && guard < 200) begin
                tick();
                guard++;
            end
            tick();
        end
        b_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [15:0] order [6];
    logic [15:0] exp_order [6];
    int snap_req, snap_a, snap_b;

    initial begin
        exp_order = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002};
        reset_n   = 1'b0;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_cmd     = '0;
        b_cmd     = '0;
        ats_ready = 1'b0;
        ats_stat  = '0;
        ats_data  = '0;
        tick();
        tick();

        // Reset state
        check("rst_a_ready", a_ready, 1);
        check("rst_b_ready", b_ready, 1);
        check("rst_rsp_valid", {a_rsp_valid, b_rsp_valid}, 0);
        check("rst_rsp_stat", {a_rsp_stat, b_rsp_stat}, 0);
        check("rst_rsp_data", {a_rsp_data, b_rsp_data} != 0, 0);
        check("rst_ats_req", ats_req, 0);
        check("rst_ctrl", {ats_ctrlA, ats_ctrlB}, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        reset_n = 1'b1;
        tick();

        // Single A command with exact latency
        a_cmd   = 32'h0001_0005;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        check("t1_a_ready_low", a_ready, 0);
        check("t1_idle_no_req", ats_req, 0);
        check("t1_idle_busy", busy, 0);
        tick();
        check("t1_issue_req", ats_req, 1);
        check("t1_ctrlA", ats_ctrlA, 32'h0001);
        check("t1_ctrlB", ats_ctrlB, 32'h0005);
        check("t1_issue_busy", busy, 1);
        tick();
        check("t1_req_one_cycle", ats_req, 0);
        tick();
        tick();
        ats_ready = 1'b1;
        ats_stat  = 2'b01;
        ats_data  = 24'h000003;
        tick();
        ats_ready = 1'b0;
        check("t1_rsp_valid", a_rsp_valid, 1);
        check("t1_rsp_stat", a_rsp_stat, 2'b01);
        check("t1_rsp_data", a_rsp_data, 24'h000003);
        check("t1_b_rsp_quiet", b_rsp_valid, 0);
        check("t1_a_ready_in_resp", a_ready, 0);
        check("t1_ctrl_stable", {ats_ctrlA, ats_ctrlB}, 32'h0001_0005);
        tick();
        check("t1_rsp_one_cycle", a_rsp_valid, 0);
        check("t1_a_ready_back", a_ready, 1);
        check("t1_busy_done", busy, 0);
        check("t1_stat_hold", a_rsp_stat, 2'b01);

        // Tie with A served last: B goes first
        a_cmd   = 32'h1111_0001;
        b_cmd   = 32'h2222_0002;
        a_valid = 1'b1;
        b_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_req(10);
        check("tie_b_first", ats_ctrlA, 32'h2222);
        respond(1, 2'b00, 24'h000010);
        check("tie_b_rsp", b_rsp_valid, 1);
        check("tie_b_rsp_data", b_rsp_data, 24'h000010);
        tick();
        wait_req(10);
        check("tie_a_second", ats_ctrlA, 32'h1111);
        respond(2, 2'b00, 24'h000020);
        check("tie_a_rsp", a_rsp_valid, 1);
        tick();

        // After reset, simultaneous A and B: A first
        do_reset();
        snap_req = req_cnt;
        a_cmd    = 32'hAAAA_0001;
        b_cmd    = 32'hBBBB_0002;
        a_valid  = 1'b1;
        b_valid  = 1'b1;
        tick();
        a_valid = 1'b0;
        b_valid = 1'b0;
        wait_req(10);
        check("sim_a_first", ats_ctrlA, 32'hAAAA);
        respond(1, 2'b00, 24'h000011);
        check("sim_a_rsp", a_rsp_valid, 1);
        check("sim_b_rsp_quiet", b_rsp_valid, 0);
        check("sim_b_ready_low1", b_ready, 0);
        tick();
        wait_req(10);
        check("sim_b_ctrlA", ats_ctrlA, 32'hBBBB);
        check("sim_b_ctrlB", ats_ctrlB, 32'h0002);
        check("sim_b_ready_low2", b_ready, 0);
        respond(1, 2'b10, 24'h000022);
        check("sim_b_rsp", b_rsp_valid, 1);
        check("sim_b_rsp_stat", b_rsp_stat, 2'b10);
        check("sim_b_rsp_data", b_rsp_data, 24'h000022);
        check("sim_a_data_hold", a_rsp_data, 24'h000011);
        tick();
        check("sim_b_ready_back", b_ready, 1);
        tick();
        check("sim_two_req_pulses", req_cnt - snap_req, 2);

        // Fairness with both clients continuously valid
        fork
            drive_a(3);
            drive_b(3);
            begin
                for (int k = 0; k < 6; k++) begin
                    wait_req(40);
                    order[k] = ats_ctrlA;
                    respond(1, 2'b01, 24'(k));
                end
            end
        join
        tick();
        tick();
        for (int k = 0; k < 6; k++) check($sformatf("fair_order_%0d", k), order[k], exp_order[k]);

        // Timeout: ats_ready never comes
        a_cmd   = 32'h0003_0004;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        wait_req(10);
        repeat (8) tick();
        check("to_no_rsp_early", a_rsp_valid, 0);
        check("to_no_err_early", timeout_err, 0);
        check("to_busy_waiting", busy, 1);
        tick();
        check("to_rsp_valid", a_rsp_valid, 1);
        check("to_rsp_stat", a_rsp_stat, 2'b11);
        check("to_rsp_data", a_rsp_data, 0);
        check("to_err_pulse", timeout_err, 1);
        tick();
        check("to_err_one_cycle", timeout_err, 0);
        check("to_back_idle", busy, 0);

        // ats_ready in the last WAIT cycle beats the timeout
        a_cmd   = 32'h0005_0006;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        wait_req(10);
        respond(8, 2'b10, 24'h123456);
        check("edge_rsp_valid", a_rsp_valid, 1);
        check("edge_rsp_stat", a_rsp_stat, 2'b10);
        check("edge_rsp_data", a_rsp_data, 24'h123456);
        check("edge_no_err", timeout_err, 0);
        tick();

        // Reset while waiting, with B pending behind A
        a_cmd   = 32'h0007_0008;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        b_cmd   = 32'h0009_000A;
        b_valid = 1'b1;
        tick();
        b_valid = 1'b0;
        check("rw_b_pending", b_ready, 0);
        wait_req(10);
        check("rw_a_issued", ats_ctrlA, 32'h0007);
        tick();
        snap_req = req_cnt;
        snap_a   = a_rsp_cnt;
        snap_b   = b_rsp_cnt;
        reset_n  = 1'b0;
        tick();
        check("rw_busy", busy, 0);
        check("rw_ready", {a_ready, b_ready}, 2'b11);
        check("rw_rsp_stat_cleared", a_rsp_stat, 0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check("rw_no_rsp", (a_rsp_cnt - snap_a) + (b_rsp_cnt - snap_b), 0);
        check("rw_no_req", req_cnt - snap_req, 0);
        a_cmd   = 32'h0002_0003;
        a_valid = 1'b1;
        tick();
        a_valid = 1'b0;
        wait_req(10);
        check("rw_new_ctrl", {ats_ctrlA, ats_ctrlB}, 32'h0002_0003);
        respond(2, 2'b01, 24'h000007);
        check("rw_new_rsp", a_rsp_valid, 1);
        check("rw_new_data", a_rsp_data, 24'h000007);
        tick();

        // Stray ats_ready while idle
        snap_a    = a_rsp_cnt;
        snap_b    = b_rsp_cnt;
        snap_req  = req_cnt;
        ats_ready = 1'b1;
        ats_stat  = 2'b10;
        ats_data  = 24'hFFFFFF;
        repeat (3) tick();
        check("stray_busy", busy, 0);
        ats_ready = 1'b0;
        tick();
        tick();
        check("stray_no_rsp", (a_rsp_cnt - snap_a) + (b_rsp_cnt - snap_b), 0);
        check("stray_no_req", req_cnt - snap_req, 0);
        check("stray_data_hold", a_rsp_data, 24'h000007);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
